// File: rtl/reg_bank_onehot_pkg.sv
// Shared constants and one-hot select helpers for the CPU register bank.
package reg_bank_onehot_pkg;
    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int IDX_W  = 4;
    localparam int ERR_W  = 8;

    function automatic logic is_onehot16(input logic [NREGS-1:0] sel);
        int cnt;
        cnt = 0;
        for (int i = 0; i < NREGS; i++) cnt += int'(sel[i]);
        return cnt == 1;
    endfunction
endpackage

// File: rtl/reg_bank_onehot_if.sv
// Select/data bus between the select-encode logic (master) and the register bank (slave).
interface reg_bank_onehot_if #(parameter int DATA_W = 32);
    import reg_bank_onehot_pkg::*;

    logic [NREGS-1:0]  rin_sel;
    logic [NREGS-1:0]  rout_sel;
    logic              ba_out;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx_last;
    logic              sel_err;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output rin_sel, rout_sel, ba_out, bus_in,
        input  bus_out, rd_idx, wr_idx_last, sel_err, err_cnt
    );
    modport slave (
        input  rin_sel, rout_sel, ba_out, bus_in,
        output bus_out, rd_idx, wr_idx_last, sel_err, err_cnt
    );
endinterface

// File: rtl/reg_bank_onehot_onehot16_to_bin.sv
// 16-bit one-hot to binary index encoder; inverse of the 4-to-16 decoder.
module onehot16_to_bin
    import reg_bank_onehot_pkg::*;
(
    input  logic [NREGS-1:0] sel,
    output logic [IDX_W-1:0] idx,
    output logic             one,
    output logic             multi
);
    logic [IDX_W-1:0] raw;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NREGS; i++)
            if (sel[i]) raw = raw | IDX_W'(i);
    end

    assign one   = is_onehot16(sel);
    assign multi = (|sel) && !one;
    // OR-encoding is garbage for multi-hot, so only a true one-hot yields an index
    assign idx   = one ? raw : '0;
endmodule

// File: rtl/reg_bank_onehot.sv
// 16-entry flop register bank with one-hot write/read selects, combinational read and select-error tracking.
module reg_bank_onehot #(
    parameter int DATA_W = reg_bank_onehot_pkg::DATA_W,
    parameter int NREGS  = reg_bank_onehot_pkg::NREGS
) (
    input logic              clk,
    input logic              clr,
    reg_bank_onehot_if.slave bus
);
    import reg_bank_onehot_pkg::*;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [IDX_W-1:0]             wr_idx, rd_idx;
    logic                         wr_one, wr_multi, rd_one, rd_multi;
    logic [IDX_W-1:0]             wr_idx_last;
    logic                         sel_err;
    logic [ERR_W-1:0]             err_cnt;

    onehot16_to_bin u_wr_enc (.sel(bus.rin_sel),  .idx(wr_idx), .one(wr_one), .multi(wr_multi));
    onehot16_to_bin u_rd_enc (.sel(bus.rout_sel), .idx(rd_idx), .one(rd_one), .multi(rd_multi));

    always_ff @(posedge clk or posedge clr) begin
        if (clr)         regs         <= '0;
        else if (wr_one) regs[wr_idx] <= bus.bus_in;
    end

    // Illegal read and write in one cycle still count as a single error cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_idx_last <= '0;
            sel_err     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (wr_one) wr_idx_last <= wr_idx;
            if (wr_multi || rd_multi) begin
                sel_err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // No write bypass: a same-cycle read of the target returns the stored value
    assign bus.bus_out     = (rd_one && !(bus.ba_out && rd_idx == '0)) ? regs[rd_idx] : '0;
    assign bus.rd_idx      = rd_idx;
    assign bus.wr_idx_last = wr_idx_last;
    assign bus.sel_err     = sel_err;
    assign bus.err_cnt     = err_cnt;
endmodule

// File: tb/tb_reg_bank_onehot.sv
// Scoreboard bench for reg_bank_onehot: expected reads queued at drive time, popped at the sample edge.
module tb_reg_bank_onehot;
    import reg_bank_onehot_pkg::*;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] data;
        logic [3:0]        idx;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    logic [DATA_W-1:0] mdl [NREGS];
    logic [3:0]        m_wr_last;
    logic              m_sel_err;
    int                m_err;

    always #5 clk = ~clk;

    reg_bank_onehot_if #(.DATA_W(DATA_W)) bus ();
    reg_bank_onehot #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        m_wr_last = '0;
        m_sel_err = 1'b0;
        m_err     = 0;
    endtask

    // Apply stimulus, queue the expected read for it, then wait for the sample edge.
    task automatic drive(input logic [15:0] rin, input logic [15:0] rout, input logic ba,
                         input logic [DATA_W-1:0] din, input string name);
        exp_t x;
        bus.rin_sel = rin; bus.rout_sel = rout; bus.ba_out = ba; bus.bus_in = din;
        x.name = name; x.data = '0; x.idx = '0;
        if ($countones(rout) == 1) begin
            for (int k = 0; k < NREGS; k++) if (rout[k]) x.idx = 4'(k);
            x.data = (x.idx == 4'd0 && ba) ? '0 : mdl[x.idx];
        end
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!clr) begin
            if ($countones(bus.rin_sel) == 1)
                for (int k = 0; k < NREGS; k++)
                    if (bus.rin_sel[k]) begin mdl[k] = bus.bus_in; m_wr_last = 4'(k); end
            if ($countones(bus.rin_sel) > 1 || $countones(bus.rout_sel) > 1) begin
                m_sel_err = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(16'h0000, 16'h0020, 1'b0, 32'h0, "rst_read");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== e.data || bus.rd_idx !== e.idx) begin
            n_fail++; $display("FAIL %s: got %h/%0d want %h/%0d", e.name, bus.bus_out, bus.rd_idx, e.data, e.idx);
        end
        n_run++;
        if (bus.wr_idx_last !== 4'd0 || bus.sel_err !== 1'b0 || bus.err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rst_status: got %0d/%b/%0d want 0/0/0", bus.wr_idx_last, bus.sel_err, bus.err_cnt);
        end
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_write_read();
        drive(16'h0020, 16'h0000, 1'b0, 32'hDEADBEEF, "wr5_idle");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== e.data || bus.rd_idx !== e.idx) begin
            n_fail++; $display("FAIL %s: got %h/%0d want %h/%0d", e.name, bus.bus_out, bus.rd_idx, e.data, e.idx);
        end
        tick();
        drive(16'h0000, 16'h0020, 1'b0, 32'h0, "rd5");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'hDEADBEEF || bus.rd_idx !== 4'd5 || bus.wr_idx_last !== 4'd5) begin
            n_fail++; $display("FAIL %s: got %h/%0d/%0d want deadbeef/5/5", e.name, bus.bus_out, bus.rd_idx, bus.wr_idx_last);
        end
        tick();
    endtask

    task automatic test_ba();
        drive(16'h0001, 16'h0000, 1'b1, 32'h00001234, "wr0_ba");
        void'(sb.pop_front());
        tick();
        drive(16'h0000, 16'h0001, 1'b1, 32'h0, "rd0_ba1");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== e.data || bus.bus_out !== 32'h0) begin
            n_fail++; $display("FAIL %s: got %h want 0", e.name, bus.bus_out);
        end
        tick();
        drive(16'h0000, 16'h0001, 1'b0, 32'h0, "rd0_ba0");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h00001234) begin
            n_fail++; $display("FAIL %s: got %h want 00001234", e.name, bus.bus_out);
        end
        tick();
        drive(16'h0000, 16'h0020, 1'b1, 32'h0, "rd5_ba1");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== e.data || bus.rd_idx !== e.idx) begin
            n_fail++; $display("FAIL %s: got %h/%0d want %h/%0d", e.name, bus.bus_out, bus.rd_idx, e.data, e.idx);
        end
        tick();
    endtask

    task automatic test_multihot_write();
        drive(16'h0003, 16'h0000, 1'b0, 32'hFFFFFFFF, "wr_multi");
        void'(sb.pop_front());
        tick();
        drive(16'h0000, 16'h0001, 1'b0, 32'h0, "r0_kept");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h00001234 || bus.sel_err !== 1'b1 || bus.err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL %s: got %h/%b/%0d want 00001234/1/1", e.name, bus.bus_out, bus.sel_err, bus.err_cnt);
        end
        tick();
        drive(16'h0000, 16'h0002, 1'b0, 32'h0, "r1_kept");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h0 || bus.wr_idx_last !== 4'd0) begin
            n_fail++; $display("FAIL %s: got %h/%0d want 0/0", e.name, bus.bus_out, bus.wr_idx_last);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(16'h0100, 16'h0000, 1'b0, 32'hA, "wr8_a");
        void'(sb.pop_front());
        tick();
        drive(16'h0100, 16'h0100, 1'b0, 32'hB, "rw8_old");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'hA || bus.rd_idx !== 4'd8) begin
            n_fail++; $display("FAIL %s: got %h/%0d want a/8", e.name, bus.bus_out, bus.rd_idx);
        end
        tick();
        drive(16'h0000, 16'h0100, 1'b0, 32'h0, "rd8_new");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'hB || bus.wr_idx_last !== 4'd8) begin
            n_fail++; $display("FAIL %s: got %h/%0d want b/8", e.name, bus.bus_out, bus.wr_idx_last);
        end
        tick();
    endtask

    task automatic test_zero_sel();
        drive(16'h0000, 16'h0000, 1'b0, 32'h55555555, "zero_sel");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h0 || bus.rd_idx !== 4'd0) begin
            n_fail++; $display("FAIL %s: got %h/%0d want 0/0", e.name, bus.bus_out, bus.rd_idx);
        end
        tick();
        drive(16'h0000, 16'h0120, 1'b0, 32'h0, "rd_multi");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h0 || bus.rd_idx !== e.idx) begin
            n_fail++; $display("FAIL %s: got %h/%0d want 0/%0d", e.name, bus.bus_out, bus.rd_idx, e.idx);
        end
        tick();
        drive(16'h0003, 16'h0003, 1'b0, 32'h0, "both_multi");
        void'(sb.pop_front());
        tick();
        n_run++;
        if (bus.err_cnt !== 8'(m_err) || bus.sel_err !== m_sel_err || bus.wr_idx_last !== m_wr_last) begin
            n_fail++; $display("FAIL err_count: got %0d/%b/%0d want %0d/%b/%0d", bus.err_cnt, bus.sel_err,
                               bus.wr_idx_last, m_err, m_sel_err, m_wr_last);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NREGS; i++) begin
            logic [15:0] ws, rs;
            ws = 16'(1) << i;
            rs = (i == 0) ? 16'h0 : 16'(1) << (i - 1);
            drive(ws, rs, 1'($urandom_range(0, 1)), $urandom, "b2b_rd");
            e = sb.pop_front(); n_run++;
            if (bus.bus_out !== e.data || bus.rd_idx !== e.idx) begin
                n_fail++; $display("FAIL %s[%0d]: got %h/%0d want %h/%0d", e.name, i, bus.bus_out, bus.rd_idx, e.data, e.idx);
            end
            tick();
            n_run++;
            if (bus.wr_idx_last !== m_wr_last) begin
                n_fail++; $display("FAIL b2b_wr_last[%0d]: got %0d want %0d", i, bus.wr_idx_last, m_wr_last);
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            drive(16'h0, 16'(1) << i, 1'b1, 32'h0, "b2b_readback");
            e = sb.pop_front(); n_run++;
            if (bus.bus_out !== e.data || bus.rd_idx !== e.idx) begin
                n_fail++; $display("FAIL %s[%0d]: got %h/%0d want %h/%0d", e.name, i, bus.bus_out, bus.rd_idx, e.data, e.idx);
            end
            tick();
        end
    endtask

    task automatic test_saturate_clr();
        drive(16'h0020, 16'h0000, 1'b0, 32'hCAFEF00D, "wr5_pre");
        void'(sb.pop_front());
        tick();
        for (int i = 0; i < 300; i++) begin
            drive((i % 3 == 1) ? 16'h0000 : 16'h0003, (i % 3 == 0) ? 16'h0000 : 16'h8001, 1'b0, 32'h0, "sat_rd");
            e = sb.pop_front(); n_run++;
            if (bus.bus_out !== e.data) begin
                n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, bus.bus_out, e.data);
            end
            tick();
        end
        n_run++;
        if (bus.err_cnt !== 8'd255 || bus.sel_err !== 1'b1 || m_err != 255) begin
            n_fail++; $display("FAIL err_sat: got %0d/%b want 255/1", bus.err_cnt, bus.sel_err);
        end
        bus.rin_sel = 16'h0; bus.rout_sel = 16'h0020; bus.ba_out = 1'b0;
        #2 clr = 1'b1;
        model_reset();
        #1; n_run++;
        if (bus.bus_out !== 32'h0 || bus.wr_idx_last !== 4'd0 || bus.sel_err !== 1'b0 || bus.err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL clr_async: got %h/%0d/%b/%0d want 0/0/0/0", bus.bus_out, bus.wr_idx_last,
                               bus.sel_err, bus.err_cnt);
        end
        // Write attempted across an edge with clr held must be dropped
        bus.rin_sel = 16'h0004; bus.bus_in = 32'h77;
        @(posedge clk); #1;
        clr = 1'b0;
        drive(16'h0004, 16'h0004, 1'b0, 32'h77, "abort_wr");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h0 || bus.bus_out !== e.data) begin
            n_fail++; $display("FAIL %s: got %h want 0", e.name, bus.bus_out);
        end
        tick();
        drive(16'h0000, 16'h0004, 1'b0, 32'h0, "first_wr");
        e = sb.pop_front(); n_run++;
        if (bus.bus_out !== 32'h77 || bus.wr_idx_last !== 4'd2) begin
            n_fail++; $display("FAIL %s: got %h/%0d want 77/2", e.name, bus.bus_out, bus.wr_idx_last);
        end
        tick();
    endtask

    initial begin
        bus.rin_sel = '0; bus.rout_sel = '0; bus.ba_out = 1'b0; bus.bus_in = '0;
        #1;
        test_reset();
        test_write_read();
        test_ba();
        test_multihot_write();
        test_same_cycle();
        test_zero_sel();
        test_back_to_back();
        test_saturate_clr();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
